// File: rtl/core_mem_arbiter.sv
// ---------------------------------------------------------------------------
// core_mem_arbiter
//
// Shares one memory port between an instruction fetch requester (imem) and
// a data load/store requester (dmem). Data normally wins; an instruction
// request that has waited through STARVE_LIMIT consecutive data grants wins
// the next arbitration. A small owner FIFO remembers who issued each
// accepted request so in-order memory responses can be steered back.
//
// Handshake semantics (all three request ports):
//   A requester raises *_req and holds it, with stable fields, until it
//   sees *_gnt in the same cycle. A transfer happens in a cycle where
//   req && gnt are both high. Responses are single-cycle *_rsp pulses with
//   no backpressure; *_err is meaningful only while *_rsp is high.
//
// Ports:
//   g_clk, g_reset          clock, synchronous active-high reset
//   imem_req/addr           instruction request in
//   imem_gnt/rsp/err/rdata  instruction grant and response out
//   dmem_req/addr/wen/
//     strb/wdata            data request in
//   dmem_gnt/rsp/err/rdata  data grant and response out
//   mem_req/addr/wen/
//     strb/wdata            shared request out
//   mem_gnt                 memory accepts mem_req (may depend on mem_req)
//   mem_rsp/err/rdata       in-order memory response in
// ---------------------------------------------------------------------------
module core_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        g_clk,
    input  logic        g_reset,

    input  logic        imem_req,
    input  logic [63:0] imem_addr,
    output logic        imem_gnt,
    output logic        imem_rsp,
    output logic        imem_err,
    output logic [63:0] imem_rdata,

    input  logic        dmem_req,
    input  logic [63:0] dmem_addr,
    input  logic        dmem_wen,
    input  logic [7:0]  dmem_strb,
    input  logic [63:0] dmem_wdata,
    output logic        dmem_gnt,
    output logic        dmem_rsp,
    output logic        dmem_err,
    output logic [63:0] dmem_rdata,

    output logic        mem_req,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [7:0]  mem_strb,
    output logic [63:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rsp,
    input  logic        mem_err,
    input  logic [63:0] mem_rdata
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] FULL_CNT   = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    // Owner encoding shared by the FIFO, the selection and the lock.
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Owner FIFO
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PW-1:0]              wr_ptr_q;
    logic [PW-1:0]              rd_ptr_q;
    logic [CW-1:0]              count_q;

    // Arbitration state
    logic                       lock_q;
    logic                       lock_owner_q;
    logic [SW-1:0]              starve_q;

    logic fifo_empty;
    logic fifo_full;
    logic head_owner;
    logic pop;
    logic push;
    logic req_ok;
    logic sel_owner;
    logic sel_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign head_owner = owner_q[rd_ptr_q];

    // Responses with nothing outstanding (e.g. for requests issued before a
    // reset) are dropped here.
    assign pop = mem_rsp && !fifo_empty;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a new request in the cycle its head response returns.
    assign req_ok = (imem_req || dmem_req) && (!fifo_full || pop);

    // Selection: a request left waiting on mem_gnt keeps its owner so the
    // presented fields cannot change mid-handshake.
    always_comb begin
        sel_owner = OWNER_D;
        if (lock_q) begin
            sel_owner = lock_owner_q;
        end else if (dmem_req && (starve_q < STARVE_MAX)) begin
            sel_owner = OWNER_D;
        end else if (imem_req) begin
            sel_owner = OWNER_I;
        end else begin
            sel_owner = OWNER_D;
        end
    end

    assign sel_data = (sel_owner == OWNER_D);
    assign push     = req_ok && mem_gnt;

    assign imem_gnt = push && !sel_data;
    assign dmem_gnt = push &&  sel_data;

    // Shared request fields; instruction requests never write.
    assign mem_req   = req_ok;
    assign mem_addr  = !req_ok ? '0 : (sel_data ? dmem_addr : imem_addr);
    assign mem_wen   = req_ok && sel_data && dmem_wen;
    assign mem_strb  = (req_ok && sel_data) ? dmem_strb  : '0;
    assign mem_wdata = (req_ok && sel_data) ? dmem_wdata : '0;

    // Response steering by FIFO head; data is broadcast, err follows rsp.
    assign imem_rsp   = pop && (head_owner == OWNER_I);
    assign dmem_rsp   = pop && (head_owner == OWNER_D);
    assign imem_err   = imem_rsp && mem_err;
    assign dmem_err   = dmem_rsp && mem_err;
    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            owner_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_I;
            starve_q     <= '0;
        end else begin
            if (push) begin
                owner_q[wr_ptr_q] <= sel_owner;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            lock_q       <= req_ok && !mem_gnt;
            lock_owner_q <= sel_owner;

            // Counts data grants that overtook a waiting instruction request.
            if (!imem_req || imem_gnt) begin
                starve_q <= '0;
            end else if (dmem_gnt && (starve_q != STARVE_MAX)) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_core_mem_arbiter
//
// Directed bench for core_mem_arbiter (default parameters: 4 outstanding,
// starve limit 4). Inputs change 1 time unit after the rising edge, outputs
// are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_core_mem_arbiter;

    logic        g_clk;
    logic        g_reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rsp;
    logic        imem_err;
    logic [63:0] imem_rdata;
    logic        dmem_req;
    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic [7:0]  dmem_strb;
    logic [63:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rsp;
    logic        dmem_err;
    logic [63:0] dmem_rdata;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [7:0]  mem_strb;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rsp;
    logic        mem_err;
    logic [63:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    core_mem_arbiter #(
        .MAX_OUTSTANDING(4),
        .STARVE_LIMIT   (4)
    ) dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rsp   (imem_rsp),
        .imem_err   (imem_err),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_addr  (dmem_addr),
        .dmem_wen   (dmem_wen),
        .dmem_strb  (dmem_strb),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_rsp   (dmem_rsp),
        .dmem_err   (dmem_err),
        .dmem_rdata (dmem_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_strb   (mem_strb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rsp    (mem_rsp),
        .mem_err    (mem_err),
        .mem_rdata  (mem_rdata)
    );

    // Clock
    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_req   = 1'b0;
        imem_addr  = '0;
        dmem_req   = 1'b0;
        dmem_addr  = '0;
        dmem_wen   = 1'b0;
        dmem_strb  = '0;
        dmem_wdata = '0;
        mem_gnt    = 1'b0;
        mem_rsp    = 1'b0;
        mem_err    = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        g_reset = 1'b1;
        step();
        step();
        g_reset = 1'b0;
    endtask

    initial begin
        logic [0:9] d_pat;
        logic [0:3] own;
        logic [0:4] rsp_own;

        g_reset = 1'b1;
        clear_inputs();

        // Reset state
        do_reset();
        @(negedge g_clk);
        check_val("rst_mem_req",  mem_req,  0);
        check_val("rst_imem_gnt", imem_gnt, 0);
        check_val("rst_dmem_gnt", dmem_gnt, 0);
        check_val("rst_imem_rsp", imem_rsp, 0);
        check_val("rst_dmem_rsp", dmem_rsp, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        step();

        // Starvation: both requesting, memory always ready and answering.
        do_reset();
        d_pat      = 10'b1111011110;
        imem_req   = 1'b1;
        imem_addr  = 64'h1000;
        dmem_req   = 1'b1;
        dmem_addr  = 64'h2000;
        dmem_wen   = 1'b1;
        dmem_strb  = 8'hff;
        dmem_wdata = 64'haaaa;
        mem_gnt    = 1'b1;
        mem_rsp    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge g_clk);
            check_val("starve_dgnt", dmem_gnt, d_pat[i]);
            check_val("starve_ignt", imem_gnt, !d_pat[i]);
            check_val("starve_addr", mem_addr, d_pat[i] ? 64'h2000 : 64'h1000);
            check_val("starve_wen",  mem_wen,  d_pat[i]);
            check_val("starve_strb", mem_strb, d_pat[i] ? 8'hff : 8'h00);
            step();
        end

        // Data waits on mem_gnt; instruction request arriving later must not
        // disturb the presented fields.
        do_reset();
        dmem_req  = 1'b1;
        dmem_addr = 64'h3000;
        imem_addr = 64'h1000;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) imem_req = 1'b1;
            if (c == 3) mem_gnt = 1'b1;
            @(negedge g_clk);
            check_val("hold_req",  mem_req,  1);
            check_val("hold_addr", mem_addr, 64'h3000);
            check_val("hold_dgnt", dmem_gnt, c == 3);
            check_val("hold_ignt", imem_gnt, 0);
            step();
        end
        dmem_req = 1'b0;
        @(negedge g_clk);
        check_val("hold_igrant", imem_gnt, 1);
        check_val("hold_iaddr",  mem_addr, 64'h1000);
        check_val("hold_iwen",   mem_wen,  0);
        step();

        // Instruction waits on mem_gnt; a data request arriving later must
        // not steal the port.
        do_reset();
        imem_req  = 1'b1;
        imem_addr = 64'h1008;
        dmem_addr = 64'h2008;
        @(negedge g_clk);
        check_val("ilock_addr0", mem_addr, 64'h1008);
        step();
        dmem_req = 1'b1;
        mem_gnt  = 1'b1;
        @(negedge g_clk);
        check_val("ilock_ignt", imem_gnt, 1);
        check_val("ilock_dgnt", dmem_gnt, 0);
        check_val("ilock_addr", mem_addr, 64'h1008);
        step();
        imem_req = 1'b0;
        @(negedge g_clk);
        check_val("ilock_dgnt2", dmem_gnt, 1);
        check_val("ilock_daddr", mem_addr, 64'h2008);
        step();

        // Fill to 4 outstanding (I,D,D,I), stall, then drain in order.
        do_reset();
        mem_gnt   = 1'b1;
        imem_addr = 64'h1100;
        dmem_addr = 64'h2200;
        own       = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            imem_req = !own[i];
            dmem_req = own[i];
            @(negedge g_clk);
            check_val("fill_ignt", imem_gnt, !own[i]);
            check_val("fill_dgnt", dmem_gnt, own[i]);
            step();
        end
        imem_req = 1'b0;
        dmem_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge g_clk);
            check_val("full_req",  mem_req,  0);
            check_val("full_dgnt", dmem_gnt, 0);
            step();
        end
        rsp_own = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            dmem_req  = (i == 0);
            mem_rsp   = 1'b1;
            mem_rdata = 64'h100 + 64'(i);
            @(negedge g_clk);
            check_val("drain_irsp", imem_rsp, !rsp_own[i]);
            check_val("drain_drsp", dmem_rsp, rsp_own[i]);
            check_val("drain_data", rsp_own[i] ? dmem_rdata : imem_rdata,
                      64'h100 + 64'(i));
            if (i == 0) begin
                check_val("pop_req",  mem_req,  1);
                check_val("pop_dgnt", dmem_gnt, 1);
            end
            step();
        end
        mem_rsp = 1'b1;
        @(negedge g_clk);
        check_val("empty_irsp", imem_rsp, 0);
        check_val("empty_drsp", dmem_rsp, 0);
        step();
        mem_rsp = 1'b0;

        // Error response to a data request.
        do_reset();
        dmem_req = 1'b1;
        mem_gnt  = 1'b1;
        @(negedge g_clk);
        check_val("err_dgnt", dmem_gnt, 1);
        step();
        dmem_req  = 1'b0;
        mem_rsp   = 1'b1;
        mem_err   = 1'b1;
        mem_rdata = 64'hdead;
        @(negedge g_clk);
        check_val("err_drsp", dmem_rsp, 1);
        check_val("err_derr", dmem_err, 1);
        check_val("err_irsp", imem_rsp, 0);
        check_val("err_ierr", imem_err, 0);
        step();

        // Reset with 2 outstanding: late responses are dropped.
        do_reset();
        mem_gnt  = 1'b1;
        imem_req = 1'b1;
        @(negedge g_clk);
        check_val("pre_ignt", imem_gnt, 1);
        step();
        imem_req = 1'b0;
        dmem_req = 1'b1;
        @(negedge g_clk);
        check_val("pre_dgnt", dmem_gnt, 1);
        step();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            mem_rsp = 1'b1;
            @(negedge g_clk);
            check_val("late_irsp", imem_rsp, 0);
            check_val("late_drsp", dmem_rsp, 0);
            step();
        end
        mem_rsp  = 1'b0;
        mem_gnt  = 1'b1;
        imem_req = 1'b1;
        @(negedge g_clk);
        check_val("post_ignt", imem_gnt, 1);
        step();
        imem_req = 1'b0;
        mem_rsp  = 1'b1;
        @(negedge g_clk);
        check_val("post_irsp", imem_rsp, 1);
        check_val("post_drsp", dmem_rsp, 0);
        step();
        clear_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
